// File: rtl/hazard_unit.sv
// hazard_unit
// Hazard and forwarding controller for a 3-stage RV32I pipeline
// (Fetch, Decode/Execute, Memory/Writeback).
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   Rs1DE, Rs2DE    source registers of the DE instruction
//   RdDE            destination register of the DE instruction
//   UseRs1DE/2DE    DE instruction actually reads rs1 / rs2
//   RegWriteDE      DE instruction writes rd
//   MemReadDE       DE instruction is a load
//   BranchTakenDE   DE branch/jump resolved taken
//   ForwardAE/BE    DE operand select: 1 = MW ALU result, 0 = register file
//   StallF          hold PC
//   StallDE         hold F/DE register
//   FlushDE         clear F/DE register at next edge
//   BubbleMW        insert NOP into DE/MW register at next edge
//   StallCount      saturating count of load-use stall cycles
module hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1DE,
    input  logic [REG_AW-1:0] Rs2DE,
    input  logic [REG_AW-1:0] RdDE,
    input  logic              UseRs1DE,
    input  logic              UseRs2DE,
    input  logic              RegWriteDE,
    input  logic              MemReadDE,
    input  logic              BranchTakenDE,
    output logic              ForwardAE,
    output logic              ForwardBE,
    output logic              StallF,
    output logic              StallDE,
    output logic              FlushDE,
    output logic              BubbleMW,
    output logic [CNT_W-1:0]  StallCount
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c)
            return c;
        else
            return c + CNT_W'(1);
    endfunction

    // MW-stage tracker and control state
    logic [REG_AW-1:0] rd_mw_p1;
    logic              regwr_mw_p1;
    logic              load_mw_p1;
    logic              squash_p1;
    logic [0:0]        state_p1;
    logic [CNT_W-1:0]  cnt_p1;

    logic v_de, w_de, l_de;
    logic hit1, hit2, lu, flush;

    // A wrong-path DE instruction is treated as a non-writing, non-reading op.
    assign v_de = ~squash_p1;
    assign w_de = RegWriteDE & v_de;
    assign l_de = MemReadDE & v_de;

    // x0 is never a forwarding source: the rd != 0 term guards it.
    assign hit1 = regwr_mw_p1 & (rd_mw_p1 != '0) & (Rs1DE == rd_mw_p1) & UseRs1DE & v_de;
    assign hit2 = regwr_mw_p1 & (rd_mw_p1 != '0) & (Rs2DE == rd_mw_p1) & UseRs2DE & v_de;

    // In STALL the load has already written the RF, so no second stall.
    assign lu    = (hit1 | hit2) & load_mw_p1 & (state_p1 == RUN);
    // Load-use wins over a taken branch; the branch re-resolves next cycle.
    assign flush = BranchTakenDE & v_de & ~lu;

    assign ForwardAE  = hit1 & ~load_mw_p1;
    assign ForwardBE  = hit2 & ~load_mw_p1;
    assign StallF     = lu;
    assign StallDE    = lu;
    assign BubbleMW   = lu;
    assign FlushDE    = flush;
    assign StallCount = cnt_p1;

    // DE -> MW boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_mw_p1    <= '0;
            regwr_mw_p1 <= 1'b0;
            load_mw_p1  <= 1'b0;
            squash_p1   <= 1'b0;
            state_p1    <= RUN;
            cnt_p1      <= '0;
        end else begin
            state_p1  <= lu ? STALL : RUN;
            squash_p1 <= flush;
            if (lu) begin
                rd_mw_p1    <= '0;
                regwr_mw_p1 <= 1'b0;
                load_mw_p1  <= 1'b0;
                cnt_p1      <= sat_inc(cnt_p1);
            end else begin
                rd_mw_p1    <= RdDE;
                regwr_mw_p1 <= w_de;
                load_mw_p1  <= l_de;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
// Directed-vector scoreboard bench for hazard_unit (CNT_W=2 so that
// counter saturation is reachable). The driver applies one vector per
// cycle shortly after the rising edge and queues its expected outputs;
// the monitor samples on the falling edge and checks against the queue.
module tb_hazard_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] Rs1DE, Rs2DE, RdDE;
    logic              UseRs1DE, UseRs2DE, RegWriteDE, MemReadDE, BranchTakenDE;
    logic              ForwardAE, ForwardBE, StallF, StallDE, FlushDE, BubbleMW;
    logic [CNT_W-1:0]  StallCount;

    typedef struct {
        string      name;
        logic [7:0] exp;   // {fa, fb, stallF, stallDE, bubble, flush, cnt[1:0]}
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1DE(Rs1DE), .Rs2DE(Rs2DE), .RdDE(RdDE),
        .UseRs1DE(UseRs1DE), .UseRs2DE(UseRs2DE),
        .RegWriteDE(RegWriteDE), .MemReadDE(MemReadDE),
        .BranchTakenDE(BranchTakenDE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallDE(StallDE),
        .FlushDE(FlushDE), .BubbleMW(BubbleMW),
        .StallCount(StallCount)
    );

    // Apply one cycle of stimulus and queue its hand-computed response.
    task automatic cyc(input string nm, input logic r,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic rw, input logic mr,
                       input logic bt,
                       input logic fa, input logic fb, input logic st, input logic fl,
                       input logic [1:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; Rs1DE = rs1; Rs2DE = rs2; RdDE = rd;
        UseRs1DE = u1; UseRs2DE = u2; RegWriteDE = rw; MemReadDE = mr;
        BranchTakenDE = bt;
        e.name = nm;
        e.exp  = {fa, fb, st, st, st, fl, cnt};
        q.push_back(e);
    endtask

    // Monitor: compare once per cycle on the falling edge.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {ForwardAE, ForwardBE, StallF, StallDE, BubbleMW, FlushDE, StallCount};
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got fa/fb/stF/stDE/bub/fl/cnt=%b required %b",
                             e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1; Rs1DE = '0; Rs2DE = '0; RdDE = '0;
        UseRs1DE = 0; UseRs2DE = 0; RegWriteDE = 0; MemReadDE = 0; BranchTakenDE = 0;
        repeat (2) @(posedge clk);

        //   name           rst rs1 rs2 rd  u1 u2 rw mr bt   fa fb st fl cnt
        cyc("reset",         1,  0,  0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        cyc("fwd_prod",      0,  0,  0, 5,  0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        cyc("fwd_ab",        0,  5,  5, 0,  1, 1, 0, 0, 0,   1, 1, 0, 0, 0);
        cyc("x0_prod",       0,  0,  0, 0,  0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        cyc("x0_use",        0,  0,  0, 0,  1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        cyc("lw_x7",         0,  0,  0, 7,  0, 0, 1, 1, 0,   0, 0, 0, 0, 0);
        cyc("lu_stall",      0,  0,  7, 8,  0, 1, 1, 0, 0,   0, 0, 1, 0, 0);
        cyc("lu_retry",      0,  0,  7, 8,  0, 1, 1, 0, 0,   0, 0, 0, 0, 1);
        cyc("br_take",       0,  0,  0, 0,  0, 0, 0, 0, 1,   0, 0, 0, 1, 1);
        cyc("br_shadow",     0,  0,  0, 3,  0, 0, 1, 0, 1,   0, 0, 0, 0, 1);
        cyc("sq_use",        0,  3,  0, 0,  1, 0, 0, 0, 0,   0, 0, 0, 0, 1);
        cyc("lw_x9",         0,  0,  0, 9,  0, 0, 1, 1, 0,   0, 0, 0, 0, 1);
        cyc("lu_branch",     0,  9,  0, 0,  1, 0, 0, 0, 1,   0, 0, 1, 0, 1);
        cyc("branch_retry",  0,  9,  0, 0,  1, 0, 0, 0, 1,   0, 0, 0, 1, 2);
        cyc("idle_sq",       0,  0,  0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 2);
        cyc("lw_x4",         0,  0,  0, 4,  0, 0, 1, 1, 0,   0, 0, 0, 0, 2);
        cyc("rst_in_lu",     1,  4,  0, 0,  1, 0, 0, 0, 0,   0, 0, 1, 0, 2);
        cyc("post_rst",      0,  4,  0, 0,  1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        cyc("lw_x4b",        0,  0,  0, 4,  0, 0, 1, 1, 0,   0, 0, 0, 0, 0);
        cyc("lu_both",       0,  4,  4, 0,  1, 1, 0, 0, 0,   0, 0, 1, 0, 0);
        cyc("stall_rel",     0,  0,  0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 1);

        // Four more load-use events: five in total must leave the 2-bit counter at 3.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] c0, c1;
            c0 = (1 + i > 3) ? 2'd3 : 2'(1 + i);
            c1 = (2 + i > 3) ? 2'd3 : 2'(2 + i);
            cyc("sat_lw",    0,  0,  0, 6,  0, 0, 1, 1, 0,   0, 0, 0, 0, c0);
            cyc("sat_lu",    0,  0,  6, 0,  0, 1, 0, 0, 0,   0, 0, 1, 0, c0);
            cyc("sat_rel",   0,  0,  0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, c1);
        end

        cyc("bb_ld1",        0,  2,  0, 6,  1, 0, 1, 1, 0,   0, 0, 0, 0, 3);
        cyc("bb_ld2",        0,  2,  0, 6,  1, 0, 1, 1, 0,   0, 0, 0, 0, 3);
        cyc("bb_use",        0,  6,  0, 0,  1, 0, 0, 0, 0,   0, 0, 1, 0, 3);
        cyc("end",           0,  0,  0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 3);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: got %0d pending entries required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard and forwarding controller for the 3-stage RV32I pipeline: Fetch (F), Decode/Execute (DE), Memory/Writeback (MW).
- Tracks the destination of the instruction occupying MW and compares it with the DE source registers.
- Drives the 1-bit operand-forward selects into the DE source muxes: 0 selects register-file data, 1 selects the MW ALU result.
- Generates the load-use stall and bubble, branch flush, wrong-path squash, and a stall performance counter.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, StallCount width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- Rs1DE  input  REG_AW  rs1 of DE instruction.
- Rs2DE  input  REG_AW  rs2 of DE instruction.
- RdDE  input  REG_AW  rd of DE instruction.
- UseRs1DE  input  1  DE instruction reads rs1.
- UseRs2DE  input  1  DE instruction reads rs2.
- RegWriteDE  input  1  DE instruction writes rd.
- MemReadDE  input  1  DE instruction is a load.
- BranchTakenDE  input  1  DE branch/jump resolved taken.
- ForwardAE  output  1  operand A select (1 = MW ALU result).
- ForwardBE  output  1  operand B select.
- StallF  output  1  hold PC.
- StallDE  output  1  hold F/DE register.
- FlushDE  output  1  clear F/DE register at next edge.
- BubbleMW  output  1  insert NOP into DE/MW register at next edge.
- StallCount  output  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Internal state:
  - MW tracker: RdMW, RegWrMW, LoadMW.
  - SquashQ: DE holds a wrong-path instruction.
  - FSM state: RUN or STALL.
  - StallCount.
- Reset (synchronous, clk edge with rst=1): RdMW=0, RegWrMW=0, LoadMW=0, SquashQ=0, FSM=RUN, StallCount=0. Reset mid-stall aborts the stall: all outputs read 0 in the cycle after reset.
- Effective DE controls:
  - vDE = ~SquashQ.
  - wDE = RegWriteDE & vDE.
  - lDE = MemReadDE & vDE.
- Match term: hitX = RegWrMW & (RdMW != 0) & (RsX == RdMW) & UseRsX & vDE.
- Forward selects:
  - ForwardAE = hit1 & ~LoadMW.
  - ForwardBE = hit2 & ~LoadMW.
  - Forwarding is combinational, zero latency.
  - x0 is never forwarded.
- Load-use hazard: LU = (hit1 | hit2) & LoadMW & (FSM==RUN).
- Stall outputs: StallF = StallDE = BubbleMW = LU.
- Flush: FlushDE = BranchTakenDE & vDE & ~LU. Load-use has priority over a simultaneous taken branch; the branch re-resolves in the following cycle.
- FSM transitions:
  - RUN→STALL on LU.
  - STALL→RUN unconditionally after 1 cycle. MW then holds a bubble, and the load has written the RF at the edge, so DE reads correct RF data with Forward*E=0.
  - In STALL, LU is forced 0.
- MW tracker update each edge:
  - If LU: RegWrMW<=0, LoadMW<=0, RdMW<=0 (bubble).
  - Else: RdMW<=RdDE, RegWrMW<=wDE, LoadMW<=lDE.
- Squash update: SquashQ <= FlushDE. A squashed DE instruction never writes, never stalls, and never flushes. A squashed DE instruction enters MW as a non-writing op.
- Counter: StallCount increments by 1 on each edge where LU=1 and saturates at 2^CNT_W−1 (no wrap).
- Back-to-back loads: a load following a load into the same rd with no DE use does not stall. A consumer behind the load does stall.
- Both operands hit the same rd: ForwardAE=ForwardBE=1 (non-load), or a single 1-cycle stall (load).

Test Plan:
- Forward A/B: cycle 1: DE add x5 (RegWriteDE=1, RdDE=5). Cycle 2: DE Rs1=5, Rs2=5, UseRs1=UseRs2=1. Required at cycle 2: ForwardAE=1, ForwardBE=1, no stall.
- x0 guard: producer RdDE=0, consumer Rs1DE=0 next cycle. Required: ForwardAE=0.
- Load-use: cycle 1: DE lw x7 (MemReadDE=1, RdDE=7). Cycle 2: consumer Rs2=7. Required at cycle 2: StallF=StallDE=BubbleMW=1, ForwardBE=0, StallCount 0→1. Required at cycle 3: FSM back to RUN, no stall, ForwardBE=0 (RegWrMW=0).
- Branch flush: BranchTakenDE=1 at cycle 1. Required: FlushDE=1 at cycle 1. At cycle 2, with BranchTakenDE=1, RegWriteDE=1, RdDE=3: FlushDE=0 (SquashQ=1). At cycle 3, consumer Rs1=3: ForwardAE=0.
- Stall vs branch: a load in MW feeds a taken branch in DE. Required: LU=1, FlushDE=0 that cycle. Next cycle: FlushDE=1.
- Reset mid-stall: assert rst in the LU cycle. Required next cycle: all outputs 0, StallCount=0, FSM=RUN. Saturation: with CNT_W=2, 5 load-use events leave StallCount=3.
